// File: rtl/drone_pkg.sv
// Shared definitions for the drone game round controller: state codes,
// difficulty modes, default lives per mode and counter widths.
package drone_pkg;

  localparam int unsigned ESTADO_W = 4;
  localparam int unsigned VIDAS_W  = 3;
  localparam int unsigned CONT_W   = 3;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL  = 4'd0,
    PREPARA  = 4'd1,
    ESPERA   = 4'd2,
    DESLOCA  = 4'd3,
    CHECA    = 4'd4,
    ATUALIZA = 4'd5,
    VENCEU   = 4'd6,
    PERDEU   = 4'd7
  } estado_t;

  typedef logic [1:0] modo_t;

  localparam modo_t MODO_FACIL   = 2'b00;
  localparam modo_t MODO_MEDIO   = 2'b01;
  localparam modo_t MODO_DIFICIL = 2'b10;

  localparam int unsigned VIDAS_FACIL_DEF   = 5;
  localparam int unsigned VIDAS_MEDIO_DEF   = 3;
  localparam int unsigned VIDAS_DIFICIL_DEF = 1;

  localparam logic [CONT_W-1:0] CONT_MAX = 3'd7;

endpackage

// File: rtl/controlador_rodada_if.sv
// Player-input / datapath-strobe bundle between the round controller and its neighbours.
interface controlador_rodada_if;
  import drone_pkg::*;

  logic                iniciar;
  logic                confirma;
  modo_t               modo;
  logic                colisao;
  logic                fim_mapa;
  logic                zeraPosicoes;
  logic                desloca;
  logic                checa_colisao;
  logic                atualiza;
  logic [VIDAS_W-1:0]  vidas;
  logic [CONT_W-1:0]   colisao_counter;
  logic                venceu;
  logic                perdeu;
  logic                timeout;
  logic [ESTADO_W-1:0] db_estado;

  modport master (
    output iniciar, confirma, modo, colisao, fim_mapa,
    input  zeraPosicoes, desloca, checa_colisao, atualiza,
           vidas, colisao_counter, venceu, perdeu, timeout, db_estado
  );

  modport slave (
    input  iniciar, confirma, modo, colisao, fim_mapa,
    output zeraPosicoes, desloca, checa_colisao, atualiza,
           vidas, colisao_counter, venceu, perdeu, timeout, db_estado
  );

endinterface

// File: rtl/contador_timeout.sv
// Up-counter with clear/enable; tc_o is registered and rises while the count sits at MAX-1.
module contador_timeout #(
  parameter int unsigned MAX = 5000,
  parameter int unsigned W   = $clog2(MAX)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tc_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  // Terminal count is looked ahead from cnt_d so it is valid in the same cycle as the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= (cnt_d == W'(MAX - 1));
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/controlador_rodada.sv
// Round sequencer: turns player confirmations into datapath strobes, tracks lives,
// collisions and the per-move inactivity timeout, and declares win/loss.
module controlador_rodada
  import drone_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 5000,
  parameter int unsigned VIDAS_FACIL    = VIDAS_FACIL_DEF,
  parameter int unsigned VIDAS_MEDIO    = VIDAS_MEDIO_DEF,
  parameter int unsigned VIDAS_DIFICIL  = VIDAS_DIFICIL_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  controlador_rodada_if.slave  bus
);

  estado_t             state_q, state_d;
  logic [VIDAS_W-1:0]  vidas_q, vidas_d, vidas_modo;
  logic [CONT_W-1:0]   cont_q, cont_d;
  logic                to_flag_q, to_flag_d;
  logic                zera_q, desloca_q, checa_q, atualiza_q;
  logic                venceu_q, perdeu_q, timeout_q;
  logic                timer_clr, timer_en, timer_tc;

  always_comb begin
    case (bus.modo)
      MODO_FACIL: vidas_modo = VIDAS_W'(VIDAS_FACIL);
      MODO_MEDIO: vidas_modo = VIDAS_W'(VIDAS_MEDIO);
      default:    vidas_modo = VIDAS_W'(VIDAS_DIFICIL);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    vidas_d   = vidas_q;
    cont_d    = cont_q;
    to_flag_d = to_flag_q;
    case (state_q)
      INICIAL: if (bus.iniciar) state_d = PREPARA;
      PREPARA: begin
        vidas_d   = vidas_modo;
        cont_d    = '0;
        to_flag_d = 1'b0;
        state_d   = ESPERA;
      end
      ESPERA: begin
        if (bus.confirma) begin
          state_d = DESLOCA;
        end else if (timer_tc) begin
          state_d   = PERDEU;
          to_flag_d = 1'b1;
        end
      end
      DESLOCA: state_d = CHECA;
      CHECA: begin
        if (bus.colisao) begin
          cont_d = (cont_q == CONT_MAX) ? cont_q : cont_q + CONT_W'(1);
          if (vidas_q <= VIDAS_W'(1)) begin
            vidas_d   = '0;
            to_flag_d = 1'b0;
            state_d   = PERDEU;
          end else begin
            vidas_d = vidas_q - VIDAS_W'(1);
            state_d = ATUALIZA;
          end
        end else if (bus.fim_mapa) begin
          state_d = VENCEU;
        end else begin
          state_d = ATUALIZA;
        end
      end
      ATUALIZA:        state_d = ESPERA;
      VENCEU, PERDEU:  if (bus.iniciar) state_d = PREPARA;
      default:         state_d = INICIAL;
    endcase
  end

  // Timer runs only across consecutive ESPERA cycles and is zero everywhere else.
  assign timer_en  = (state_q == ESPERA);
  assign timer_clr = (state_q != ESPERA) || (state_d != ESPERA);

  contador_timeout #(.MAX(TIMEOUT_CICLOS)) u_timer (
    .clk   (clock),
    .rst_n (reset),
    .clr_i (timer_clr),
    .en_i  (timer_en),
    .tc_o  (timer_tc)
  );

  // Strobes are decoded from the next state and registered alongside it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= INICIAL;
      vidas_q    <= '0;
      cont_q     <= '0;
      to_flag_q  <= 1'b0;
      zera_q     <= 1'b0;
      desloca_q  <= 1'b0;
      checa_q    <= 1'b0;
      atualiza_q <= 1'b0;
      venceu_q   <= 1'b0;
      perdeu_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vidas_q    <= vidas_d;
      cont_q     <= cont_d;
      to_flag_q  <= to_flag_d;
      zera_q     <= (state_d == PREPARA);
      desloca_q  <= (state_d == DESLOCA);
      checa_q    <= (state_d == CHECA);
      atualiza_q <= (state_d == ATUALIZA);
      venceu_q   <= (state_d == VENCEU);
      perdeu_q   <= (state_d == PERDEU);
      timeout_q  <= (state_d == PERDEU) && to_flag_d;
    end
  end

  assign bus.zeraPosicoes    = zera_q;
  assign bus.desloca         = desloca_q;
  assign bus.checa_colisao   = checa_q;
  assign bus.atualiza        = atualiza_q;
  assign bus.vidas           = vidas_q;
  assign bus.colisao_counter = cont_q;
  assign bus.venceu          = venceu_q;
  assign bus.perdeu          = perdeu_q;
  assign bus.timeout         = timeout_q;
  assign bus.db_estado       = ESTADO_W'(state_q);

endmodule

// File: tb/tb_controlador_rodada.sv
// Self-checking bench for controlador_rodada: directed rounds plus random rounds
// compared against a move-level game-rule model.
module tb_controlador_rodada;

  localparam int unsigned TO = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  controlador_rodada_if bus();

  controlador_rodada #(.TIMEOUT_CICLOS(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int m_vidas = 0;
  int m_cont  = 0;
  bit m_to    = 1'b0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow from the state the game rules say we are in.
  task automatic check_all(input string tag, input int st, input bit with_cnt);
    chk({tag, ".estado"},   32'(bus.db_estado),     32'(st));
    chk({tag, ".zera"},     32'(bus.zeraPosicoes),  32'(st == 1));
    chk({tag, ".desloca"},  32'(bus.desloca),       32'(st == 3));
    chk({tag, ".checa"},    32'(bus.checa_colisao), 32'(st == 4));
    chk({tag, ".atualiza"}, 32'(bus.atualiza),      32'(st == 5));
    chk({tag, ".venceu"},   32'(bus.venceu),        32'(st == 6));
    chk({tag, ".perdeu"},   32'(bus.perdeu),        32'(st == 7));
    chk({tag, ".timeout"},  32'(bus.timeout),       32'((st == 7) && m_to));
    if (with_cnt) begin
      chk({tag, ".vidas"},  32'(bus.vidas),           32'(m_vidas));
      chk({tag, ".cont"},   32'(bus.colisao_counter), 32'(m_cont));
    end
  endtask

  function automatic int lives_of(input logic [1:0] modo);
    case (modo)
      2'b00:   return 5;
      2'b01:   return 3;
      default: return 1;
    endcase
  endfunction

  task automatic start_round(input logic [1:0] modo);
    bus.modo    = modo;
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    check_all("prepara", 1, 1'b0);
    m_vidas = lives_of(modo);
    m_cont  = 0;
    m_to    = 1'b0;
    tick();
    bus.modo = 2'($urandom_range(0, 3));
    check_all("inicio", 2, 1'b1);
  endtask

  // res: 0 round continues, 1 won, 2 lost.
  task automatic do_move(input int unsigned d, input bit col, input bit fim, output int res);
    bus.confirma = 1'b0;
    for (int i = 0; i < int'(d); i++) begin
      tick();
      check_all("espera", 2, 1'b1);
    end
    bus.confirma = 1'b1;
    bus.colisao  = col;
    bus.fim_mapa = fim;
    tick();
    bus.confirma = 1'b0;
    check_all("desloca", 3, 1'b1);
    tick();
    check_all("checa", 4, 1'b1);
    res = 0;
    if (col) begin
      m_cont  = (m_cont < 7) ? m_cont + 1 : 7;
      m_vidas = m_vidas - 1;
      if (m_vidas == 0) begin
        res  = 2;
        m_to = 1'b0;
      end
    end else if (fim) begin
      res = 1;
    end
    tick();
    bus.colisao  = 1'b0;
    bus.fim_mapa = 1'b0;
    case (res)
      0: begin
        check_all("atualiza", 5, 1'b1);
        tick();
        check_all("volta", 2, 1'b1);
      end
      1:       check_all("venceu", 6, 1'b1);
      default: check_all("perdeu", 7, 1'b1);
    endcase
  endtask

  task automatic wait_timeout();
    for (int i = 0; i < int'(TO) - 1; i++) begin
      tick();
      check_all("pre_to", 2, 1'b1);
    end
    tick();
    m_to = 1'b1;
    check_all("timeout", 7, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int res;
    reset        = 1'b0;
    bus.iniciar  = 1'b0;
    bus.confirma = 1'b0;
    bus.modo     = 2'b00;
    bus.colisao  = 1'b0;
    bus.fim_mapa = 1'b0;
    repeat (2) tick();
    check_all("reset", 0, 1'b1);
    reset = 1'b1;
    tick();
    check_all("idle", 0, 1'b1);

    // Medium: three clean moves keep all lives.
    start_round(2'b01);
    repeat (3) do_move($urandom_range(0, TO - 2), 1'b0, 1'b0, res);

    // Collision beats end-of-map, then a clean move on the last tile wins.
    do_move(2, 1'b1, 1'b1, res);
    do_move(3, 1'b0, 1'b1, res);
    bus.confirma = 1'b1;
    tick();
    bus.confirma = 1'b0;
    check_all("venceu_hold", 6, 1'b1);

    // Easy from VENCEU: lives reload, counter restarts, five hits lose the round.
    start_round(2'b00);
    repeat (5) do_move(1, 1'b1, 1'b0, res);
    tick();
    check_all("perdeu_hold", 7, 1'b1);

    // Hard: single hit loses without timeout.
    start_round(2'b10);
    do_move(0, 1'b1, 1'b0, res);

    // Mode 11 behaves as hard; idle player times out.
    start_round(2'b11);
    wait_timeout();

    // confirma on the last allowed cycle wins over timeout.
    start_round(2'b01);
    do_move(TO - 1, 1'b0, 1'b0, res);
    wait_timeout();

    // Random rounds against the rule model.
    for (int r = 0; r < 8; r++) begin
      start_round(2'($urandom_range(0, 3)));
      res = 0;
      for (int mv = 0; mv < 10 && res == 0; mv++) begin
        bit c, f;
        c = ($urandom_range(0, 99) < 35);
        f = ($urandom_range(0, 99) < 15);
        do_move($urandom_range(0, TO - 1), c, f, res);
      end
      if (res == 0) wait_timeout();
    end

    // Asynchronous reset while in DESLOCA takes effect before the next edge.
    start_round(2'b01);
    bus.confirma = 1'b1;
    tick();
    bus.confirma = 1'b0;
    check_all("pre_reset", 3, 1'b1);
    reset = 1'b0;
    #1;
    m_vidas = 0;
    m_cont  = 0;
    m_to    = 1'b0;
    check_all("reset_async", 0, 1'b1);
    #1;
    reset = 1'b1;
    tick();
    check_all("pos_reset", 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
